spi_command_decoder: RTL and testbench
======================================

SPI_COMMAND_DECODER -- requirements
Module: spi_command_decoder

Interface
REQ-001 The module SHALL have parameter VERSION, default 64'h0000_0000_0001_0000, meaning the 64-bit constant returned by the VERSION command.
REQ-002 The module SHALL have port clk, input, 1 bit, the system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port resetn, input, 1 bit, reset: asynchronous and active-low.
REQ-004 The module SHALL have port word_received, input, 1 bit, a level from the SPI word receiver that is high while a complete 64-bit word is held.
REQ-005 The module SHALL have port word_data_received, input, 64 bits, the received word, valid when word_received is high.
REQ-006 The module SHALL have port word_send_data, output, 64 bits, the reply word shifted out during the next SPI word.
REQ-007 The module SHALL have port move_valid, output, 1 bit, high when a move command is offered downstream.
REQ-008 The module SHALL have port move_ready, input, 1 bit, asserted by the downstream motion stage to accept a move.
REQ-009 The module SHALL have port move_increment, output, 32 bits, the signed per-tick increment of the offered move.
REQ-010 The module SHALL have port move_duration, output, 32 bits, the tick count of the offered move.
REQ-011 The module SHALL have port enable, output, 1 bit, the driver enable.
REQ-012 The module SHALL have port microsteps, output, 3 bits, the microstep setting.
REQ-013 The module SHALL have port error, output, 1 bit, a sticky flag for an unknown command or a dropped move.

Function
REQ-014 A new word SHALL be detected on the 0->1 transition of the registered word_received (one-cycle pulse); a level held high SHALL NOT be processed twice.
REQ-015 The header command byte SHALL be word_data_received[63:56].
REQ-016 The FSM SHALL have states IDLE (expect header) and PAYLOAD (expect the MOVE payload word).
REQ-017 In IDLE, header 0x01 (MOVE) SHALL cause a transition to PAYLOAD.
REQ-018 In PAYLOAD, the next word SHALL be taken as the MOVE payload: duration = [63:32], increment = [31:0]; the FSM SHALL then return to IDLE.
REQ-019 Header 0x02 (ENABLE) SHALL set enable to header bit[0].
REQ-020 Header 0x03 (MICROSTEP) SHALL set microsteps to header bits[2:0].
REQ-021 Header 0x0A (STATUS) SHALL load word_send_data with {8'h0A, 52'b0, pending_valid, enable, error, 1'b0}.
REQ-022 Header 0xFE (VERSION) SHALL load word_send_data with VERSION.
REQ-023 An unknown header SHALL set error, leave all other state unchanged, and keep the FSM in IDLE.
REQ-024 word_send_data SHALL be loaded one cycle after the header pulse, and SHALL be cleared to 0 on the next word pulse unless that word itself loads a reply.
REQ-025 The move output SHALL use a single-entry pending register: move_valid = pending_valid, with fields driven from the register.
REQ-026 A handshake SHALL occur when move_valid && move_ready; pending_valid SHALL clear the following cycle unless a new payload loads in the same cycle.
REQ-027 A payload arriving with the register empty, or in the same cycle as a handshake, SHALL load it and set pending_valid, with no error.
REQ-028 A payload arriving while the register is full and no handshake occurs SHALL be dropped, set error, and leave the register unchanged.
REQ-029 The move fields SHALL remain stable while move_valid is high and move_ready is low.
REQ-030 error SHALL be cleared only by reset or by a STATUS read (cleared after its value is captured into the reply).

Reset
REQ-031 On resetn low, all state SHALL clear immediately: FSM = IDLE, word_send_data = 0, move_valid = 0, move fields = 0, enable = 0, microsteps = 0, error = 0.
REQ-032 A reset asserted in PAYLOAD SHALL abandon the partial command; the first word after reset SHALL be treated as a header.
REQ-033 resetn SHALL be deasserted synchronously to clk.

Verification
REQ-034 Send header 0x01.., then payload 64'h0000_0100_FFFF_FFFE, with move_ready=0 -> move_valid=1, duration=0x100, increment=-2, stable until move_ready=1, then move_valid=0 the next cycle.
REQ-035 Send two MOVEs with move_ready held 0 -> first is retained, second is dropped, error=1; a STATUS read returns bit1=1, after which error=0.
REQ-036 Send a payload on the same cycle as the handshake -> no error, move_valid stays 1 with the new fields.
REQ-037 Send header 0xFE -> word_send_data=VERSION, then 0 after the following non-reply word; send 0x02 with bit0=1 and 0x03 with bits[2:0]=5 -> enable=1, microsteps=5.
REQ-038 Hold word_received high for 20 cycles -> exactly one word processed; send header 0x77 -> error=1 with the FSM in IDLE.
REQ-039 Send MOVE header, pulse resetn low, then send 0x02 with bit0=1 -> it is decoded as ENABLE, enable=1, no move is produced.

Source files
------------

// File: rtl/spi_command_decoder.sv
// Purpose: decodes 64-bit SPI command words into a pending move, driver settings and a reply word.
// Latency: replies and settings are updated one cycle after the new-word pulse (two cycles after word_received rises).
// Backpressure: a single pending move is held until move_valid && move_ready; a payload that arrives while it is full is dropped and flags error.
//
// Ports:
//   clk, resetn                 - clock, asynchronous active-low reset (deasserted synchronously)
//   word_received               - level, high while a complete word is held by the SPI receiver
//   word_data_received[63:0]    - received word; header command byte is [63:56]
//   word_send_data[63:0]        - reply shifted out during the next SPI word
//   move_valid/move_ready       - move offer handshake towards the motion stage
//   move_increment[31:0]        - signed per-tick increment of the offered move
//   move_duration[31:0]         - tick count of the offered move
//   enable, microsteps[2:0]     - driver settings
//   error                       - sticky: unknown command or dropped move; cleared by a STATUS read
module spi_command_decoder #(
    parameter logic [63:0] VERSION = 64'h0000_0000_0001_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        word_received,
    input  logic [63:0] word_data_received,
    output logic [63:0] word_send_data,
    output logic        move_valid,
    input  logic        move_ready,
    output logic [31:0] move_increment,
    output logic [31:0] move_duration,
    output logic        enable,
    output logic [2:0]  microsteps,
    output logic        error
);

    localparam logic [7:0] CMD_MOVE      = 8'h01;
    localparam logic [7:0] CMD_ENABLE    = 8'h02;
    localparam logic [7:0] CMD_MICROSTEP = 8'h03;
    localparam logic [7:0] CMD_STATUS    = 8'h0A;
    localparam logic [7:0] CMD_VERSION   = 8'hFE;

    typedef enum logic {
        IDLE,
        PAYLOAD
    } state_t;

    state_t      state, state_nxt;
    logic        rcv_q, rcv_qq;
    logic [63:0] data_q;
    logic        word_pulse;
    logic [7:0]  cmd;
    logic        handshake;

    logic        do_payload, do_enable, do_micro, do_status, do_version, do_unknown;
    logic        load_move, drop_move;
    logic [63:0] status_word;

    // The level is registered twice so a word held high for many cycles
    // yields exactly one pulse; data is registered alongside it.
    assign word_pulse  = rcv_q & ~rcv_qq;
    assign cmd         = data_q[63:56];
    assign handshake   = move_valid & move_ready;
    // A freed slot in the same cycle as the payload still accepts it.
    assign load_move   = do_payload & (~move_valid | handshake);
    assign drop_move   = do_payload & move_valid & ~handshake;
    assign status_word = {CMD_STATUS, 52'b0, move_valid, enable, error, 1'b0};

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (word_pulse && cmd == CMD_MOVE) state_nxt = PAYLOAD;
            PAYLOAD: if (word_pulse) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        do_payload = 1'b0;
        do_enable  = 1'b0;
        do_micro   = 1'b0;
        do_status  = 1'b0;
        do_version = 1'b0;
        do_unknown = 1'b0;
        if (word_pulse) begin
            if (state == PAYLOAD) begin
                do_payload = 1'b1;
            end else begin
                case (cmd)
                    CMD_MOVE:      ;
                    CMD_ENABLE:    do_enable  = 1'b1;
                    CMD_MICROSTEP: do_micro   = 1'b1;
                    CMD_STATUS:    do_status  = 1'b1;
                    CMD_VERSION:   do_version = 1'b1;
                    default:       do_unknown = 1'b1;
                endcase
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rcv_q          <= 1'b0;
            rcv_qq         <= 1'b0;
            data_q         <= '0;
            word_send_data <= '0;
            move_valid     <= 1'b0;
            move_increment <= '0;
            move_duration  <= '0;
            enable         <= 1'b0;
            microsteps     <= '0;
            error          <= 1'b0;
        end else begin
            rcv_q  <= word_received;
            rcv_qq <= rcv_q;
            data_q <= word_data_received;

            // Every word replaces the reply; only STATUS/VERSION leave a non-zero one.
            if (word_pulse) begin
                if (do_status)       word_send_data <= status_word;
                else if (do_version) word_send_data <= VERSION;
                else                 word_send_data <= '0;
            end

            if (do_enable) enable     <= data_q[0];
            if (do_micro)  microsteps <= data_q[2:0];

            // status_word captured the old error above, so clearing here is safe.
            if (do_unknown || drop_move) error <= 1'b1;
            else if (do_status)          error <= 1'b0;

            if (load_move) begin
                move_valid     <= 1'b1;
                move_duration  <= data_q[63:32];
                move_increment <= data_q[31:0];
            end else if (handshake) begin
                move_valid     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_command_decoder.sv
module tb_spi_command_decoder;

    localparam logic [63:0] TB_VERSION = 64'hA5A5_0123_4567_89AB;

    logic        clk = 1'b0;
    logic        resetn;
    logic        word_received;
    logic [63:0] word_data_received;
    logic [63:0] word_send_data;
    logic        move_valid;
    logic        move_ready;
    logic [31:0] move_increment;
    logic [31:0] move_duration;
    logic        enable;
    logic [2:0]  microsteps;
    logic        error;

    spi_command_decoder #(.VERSION(TB_VERSION)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .word_received      (word_received),
        .word_data_received (word_data_received),
        .word_send_data     (word_send_data),
        .move_valid         (move_valid),
        .move_ready         (move_ready),
        .move_increment     (move_increment),
        .move_duration      (move_duration),
        .enable             (enable),
        .microsteps         (microsteps),
        .error              (error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Word-level reference model of the decoder's visible state.
    logic        m_await;
    logic        m_valid;
    logic [31:0] m_dur;
    logic [31:0] m_inc;
    logic        m_en;
    logic [2:0]  m_ms;
    logic        m_err;
    logic [63:0] m_reply;

    task automatic model_reset();
        m_await = 0; m_valid = 0; m_dur = 0; m_inc = 0;
        m_en = 0; m_ms = 0; m_err = 0; m_reply = 0;
    endtask

    // Applies one word as the command protocol describes, assuming no handshake during it.
    task automatic model_word(input logic [63:0] w);
        logic [7:0] c;
        c = w[63:56];
        m_reply = 64'h0;
        if (m_await) begin
            m_await = 0;
            if (!m_valid) begin
                m_valid = 1; m_dur = w[63:32]; m_inc = w[31:0];
            end else begin
                m_err = 1;
            end
        end else begin
            case (c)
                8'h01: m_await = 1;
                8'h02: m_en = w[0];
                8'h03: m_ms = w[2:0];
                8'h0A: begin
                    m_reply = {8'h0A, 52'h0, m_valid, m_en, m_err, 1'b0};
                    m_err = 0;
                end
                8'hFE: m_reply = TB_VERSION;
                default: m_err = 1;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".move_valid"}, {63'h0, move_valid}, {63'h0, m_valid});
        chk({tag, ".enable"},     {63'h0, enable},     {63'h0, m_en});
        chk({tag, ".microsteps"}, {61'h0, microsteps}, {61'h0, m_ms});
        chk({tag, ".error"},      {63'h0, error},      {63'h0, m_err});
        chk({tag, ".reply"},      word_send_data,      m_reply);
        if (m_valid) begin
            chk({tag, ".duration"},  {32'h0, move_duration},  {32'h0, m_dur});
            chk({tag, ".increment"}, {32'h0, move_increment}, {32'h0, m_inc});
        end
    endtask

    task automatic send_word(input logic [63:0] w, input int hold);
        @(negedge clk);
        word_data_received = w;
        word_received = 1'b1;
        repeat (hold) @(negedge clk);
        word_received = 1'b0;
        repeat (3) @(negedge clk);
        model_word(w);
    endtask

    task automatic accept_move(input string tag);
        @(negedge clk);
        move_ready = 1'b1;
        @(negedge clk);
        move_ready = 1'b0;
        m_valid = 0;
        chk({tag, ".valid_after_accept"}, {63'h0, move_valid}, 64'h0);
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".in_reset"});
        chk({tag, ".fields_in_reset"}, {move_duration, move_increment}, 64'h0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    function automatic logic [7:0] random_unknown();
        logic [7:0] c;
        c = 8'($urandom_range(0, 255));
        while (c == 8'h01 || c == 8'h02 || c == 8'h03 || c == 8'h0A || c == 8'hFE)
            c = 8'($urandom_range(0, 255));
        return c;
    endfunction

    initial begin
        logic [63:0] w;
        logic        seen_drop;
        int          kind;

        resetn = 1'b0;
        word_received = 1'b0;
        word_data_received = 64'h0;
        move_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset.fields", {move_duration, move_increment}, 64'h0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Single move held under backpressure, then accepted.
        send_word({8'h01, 56'h0}, 1);
        check_all("move_hdr");
        send_word(64'h0000_0100_FFFF_FFFE, 2);
        check_all("move_payload");
        chk("move.duration_const",  {32'h0, move_duration},  64'h100);
        chk("move.increment_const", {32'h0, move_increment}, {32'h0, 32'hFFFF_FFFE});
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("move.stable", {move_duration, move_increment}, 64'h0000_0100_FFFF_FFFE);
            chk("move.valid_held", {63'h0, move_valid}, 64'h1);
        end
        accept_move("move");

        // Second move dropped while the first is pending; STATUS reports and clears error.
        send_word({8'h01, 56'h0}, 1);
        send_word(64'h0000_0011_0000_0022, 1);
        send_word({8'h01, 56'h0}, 1);
        send_word(64'h0000_0033_0000_0044, 1);
        check_all("drop");
        chk("drop.error", {63'h0, error}, 64'h1);
        send_word({8'h0A, 56'h0}, 1);
        check_all("drop.status");
        chk("drop.status_bit1", {63'h0, word_send_data[1]}, 64'h1);
        chk("drop.error_cleared", {63'h0, error}, 64'h0);

        // Payload arriving in the same cycle as the handshake.
        send_word({8'h01, 56'h0}, 1);
        @(negedge clk);
        word_data_received = 64'h0000_0055_0000_0066;
        word_received = 1'b1;
        @(negedge clk);
        move_ready = 1'b1;
        word_received = 1'b0;
        @(negedge clk);
        move_ready = 1'b0;
        repeat (2) @(negedge clk);
        m_await = 0; m_valid = 1; m_dur = 32'h55; m_inc = 32'h66; m_reply = 0;
        check_all("same_cycle");
        accept_move("same_cycle");

        // VERSION reply, cleared by the next non-reply word; ENABLE and MICROSTEP.
        send_word({8'hFE, 56'h0}, 1);
        check_all("version");
        send_word({8'h02, 55'h0, 1'b1}, 1);
        check_all("enable");
        send_word({8'h03, 53'h0, 3'd5}, 1);
        check_all("microstep");

        // A long-held word is processed once; unknown header leaves FSM in IDLE.
        send_word({8'h01, 56'h0}, 20);
        send_word(64'h0000_0007_0000_0008, 1);
        check_all("held20");
        accept_move("held20");
        send_word({8'h77, 56'h0}, 1);
        check_all("unknown");
        send_word({8'h02, 56'h0}, 1);
        check_all("unknown.idle");
        send_word({8'h0A, 56'h0}, 1);
        check_all("unknown.status");

        // Reset abandons a partial MOVE.
        send_word({8'h01, 56'h0}, 1);
        pulse_reset("rst_mid");
        send_word({8'h02, 55'h0, 1'b1}, 1);
        check_all("rst_mid.enable");

        // Randomized command stream.
        seen_drop = 0;
        for (int i = 0; i < 150; i++) begin
            if (m_await) begin
                w = {32'($urandom), 32'($urandom)};
                if (m_valid) seen_drop = 1;
            end else begin
                kind = $urandom_range(0, 9);
                w = {8'h00, 24'($urandom), 32'($urandom)};
                case (kind)
                    0, 1, 2: w[63:56] = 8'h01;
                    3:       w[63:56] = 8'h02;
                    4:       w[63:56] = 8'h03;
                    5:       w[63:56] = 8'h0A;
                    6:       w[63:56] = 8'hFE;
                    7:       w[63:56] = random_unknown();
                    default: begin
                        if (m_valid) accept_move("rand");
                        w[63:56] = 8'h0A;
                    end
                endcase
            end
            send_word(w, $urandom_range(1, 3));
            check_all("rand");
        end
        n_checks++;
        assert (seen_drop) else begin
            n_errors++;
            $error("FAIL rand.coverage observed=%0d expected=1", seen_drop);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Whole run is far below this; guards against a stuck bench.
    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
